// File: rtl/five_op_pkg.sv
// Shared types for the push-button accumulator: FSM state encoding and width helpers.
package five_op_pkg;

  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    CAPT = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Accumulator width for a W-bit operand: up to eight operands never overflow W+3 bits.
  function automatic int acc_w(input int w);
    return w + 3;
  endfunction

endpackage

// File: rtl/pb_sync_edge.sv
// One push-button front end: 2-flop synchronizer, optional debounce filter, rising-edge pulse.
// Debounce filter is present only when PB_DEBOUNCE_EN is defined.
module pb_sync_edge #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic press
);

`ifdef PB_DEBOUNCE_EN
  localparam int DB_EN = 1;
`else
  localparam int DB_EN = 0;
`endif
  localparam int DB_EFF = DB_EN * DB_CYCLES;

  logic sync1_reg;
  logic sync2_reg;
  logic level;
  logic level_d_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= pb;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    if (DB_EFF > 0) begin : g_db
      localparam int CNT_W = $clog2(DB_EFF + 1);
      logic [CNT_W-1:0] cnt_reg;
      logic             filt_reg;

      // Filtered level follows the synchronized level only after DB_EFF consecutive differing cycles.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg  <= '0;
          filt_reg <= 1'b0;
        end else if (sync2_reg == filt_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_W'(DB_EFF - 1)) begin
          cnt_reg  <= '0;
          filt_reg <= sync2_reg;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign level = filt_reg;
    end else begin : g_nodb
      assign level = sync2_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d_reg <= 1'b0;
    end else begin
      level_d_reg <= level;
    end
  end

  assign press = level & ~level_d_reg;

endmodule

// File: rtl/five_op_accum_ctrl.sv
// Sequencer that sums N_OPS button-qualified operands through one shared adder path.
// Optional input debounce is enabled with PB_DEBOUNCE_EN.
module five_op_accum_ctrl
  import five_op_pkg::*;
#(
  parameter int N_OPS     = 5,
  parameter int W         = 4,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_OPS-1:0] pb,
  input  logic [W-1:0]     y,
  input  logic             clear,
  output logic [W+1:0]     sum,
  output logic             carry,
  output logic [IDX_W-1:0] op_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int ACC_W = acc_w(W);

  logic [N_OPS-1:0] press;
  logic [N_OPS-1:0] exp_press;

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [W-1:0]     opnd_reg, opnd_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             err_reg, err_next;

  generate
    for (genvar gi = 0; gi < N_OPS; gi++) begin : g_pb
      pb_sync_edge #(
        .DB_CYCLES(DB_CYCLES)
      ) u_pb (
        .clk  (clk),
        .rst  (rst),
        .pb   (pb[gi]),
        .press(press[gi])
      );
    end
  endgenerate

  assign exp_press = {{(N_OPS-1){1'b0}}, 1'b1} << idx_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= WAIT;
      acc_reg   <= '0;
      opnd_reg  <= '0;
      idx_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      opnd_reg  <= opnd_next;
      idx_reg   <= idx_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    opnd_next  = opnd_reg;
    idx_next   = idx_reg;
    err_next   = err_reg;
    if (clear) begin
      // Restart wins over any press arriving in the same cycle.
      state_next = WAIT;
      acc_next   = '0;
      opnd_next  = '0;
      idx_next   = '0;
      err_next   = 1'b0;
    end else begin
      case (state_reg)
        WAIT: begin
          if (press != '0) begin
            if (press == exp_press) begin
              opnd_next  = y;
              state_next = CAPT;
            end else begin
              err_next = 1'b1;
            end
          end
        end
        CAPT: state_next = ADD;
        ADD: begin
          acc_next = acc_reg + ACC_W'(opnd_reg);
          if (idx_reg == IDX_W'(N_OPS - 1)) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = WAIT;
          end
        end
        DONE: state_next = DONE;
        default: state_next = WAIT;
      endcase
    end
  end

  assign sum    = acc_reg[W+1:0];
  assign carry  = acc_reg[ACC_W-1];
  assign op_idx = idx_reg;
  assign busy   = (state_reg == CAPT) || (state_reg == ADD);
  assign done   = (state_reg == DONE);
  assign err    = err_reg;

endmodule

// File: tb/tb_five_op_accum_ctrl.sv
// Self-checking bench for five_op_accum_ctrl: vector table, scoreboard queue, corner-case sequences.
// Debounce checks run only when PB_DEBOUNCE_EN is defined.
module tb_five_op_accum_ctrl;

  localparam int N  = 5;
  localparam int W  = 4;
  localparam int DB = 4;
`ifdef PB_DEBOUNCE_EN
  localparam int LAT = 5 + DB;
`else
  localparam int LAT = 5;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] pb;
  logic [W-1:0] y;
  logic         clear;
  logic [W+1:0] sum;
  logic         carry;
  logic [2:0]   op_idx;
  logic         busy;
  logic         done;
  logic         err;

  five_op_accum_ctrl #(
    .N_OPS    (N),
    .W        (W),
    .DB_CYCLES(DB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .pb    (pb),
    .y     (y),
    .clear (clear),
    .sum   (sum),
    .carry (carry),
    .op_idx(op_idx),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] y;
    logic [6:0]   total;
    logic         done;
  } vec_t;

  vec_t       vecs[4];
  logic [6:0] sb_q[$];
  logic [6:0] model_acc;
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    model_acc = '0;
    sb_q.delete();
  endtask

  // Accepted press: {carry,sum} must hold for LAT-1 edges and update on edge LAT.
  task automatic press_ok(input int b, input logic [W-1:0] v);
    logic [6:0] exp;
    y = v;
    pb[b] = 1'b1;
    sb_q.push_back(model_acc + 7'(v));
    tick(LAT - 1);
    check("acc_before_commit", {carry, sum}, model_acc);
    check("busy_in_add", busy, 1'b1);
    tick(1);
    exp = sb_q.pop_front();
    check("acc_after_commit", {carry, sum}, exp);
    $display("press pb[%0d] y=%0d -> acc=%0d op_idx=%0d", b, v, {carry, sum}, op_idx);
    model_acc = exp;
    pb[b] = 1'b0;
    tick(LAT + 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{y: 4'h0, total: 7'd0,  done: 1'b1};
    vecs[1] = '{y: 4'hF, total: 7'd75, done: 1'b1};
    vecs[2] = '{y: 4'hA, total: 7'd50, done: 1'b1};
    vecs[3] = '{y: 4'h3, total: 7'd15, done: 1'b1};

    rst = 1'b1; pb = '0; y = '0; clear = 1'b0; model_acc = '0;
    tick(2);
    check("reset_sum", sum, 0);
    check("reset_carry", carry, 0);
    check("reset_op_idx", op_idx, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    rst = 1'b0;
    tick(2);

    for (int v = 0; v < 4; v++) begin
      do_clear();
      for (int i = 0; i < N; i++) press_ok(i, vecs[v].y);
      check("vec_total", {carry, sum}, vecs[v].total);
      check("vec_done", done, vecs[v].done);
      check("vec_op_idx", op_idx, N - 1);
      check("vec_err", err, 0);
    end

    // Presses in DONE are silently dropped.
    pb[0] = 1'b1; y = 4'h9;
    tick(LAT + 2);
    check("done_ignore_acc", {carry, sum}, 15);
    check("done_ignore_err", err, 0);
    check("done_hold", done, 1);
    pb = '0;
    tick(LAT + 2);

    // Out-of-order press flags err and accumulates nothing.
    do_clear();
    y = 4'd5; pb[2] = 1'b1;
    tick(LAT + 1);
    check("ooo_err", err, 1);
    check("ooo_sum", sum, 0);
    check("ooo_op_idx", op_idx, 0);
    pb = '0;
    tick(LAT + 2);
    press_ok(0, 4'd5);
    check("ooo_then_ok_idx", op_idx, 1);
    check("ooo_err_sticky", err, 1);
    // Simultaneous press including the expected button is still an error.
    pb = 5'b00011;
    tick(LAT + 1);
    check("multi_sum", sum, 5);
    check("multi_op_idx", op_idx, 1);
    pb = '0;
    tick(LAT + 2);

    // Clear in the same cycle the press pulse is seen.
    do_clear();
    press_ok(0, 4'd7);
    press_ok(1, 4'd7);
    check("pre_clear_sum", sum, 14);
    y = 4'd7; pb[2] = 1'b1;
    tick(LAT - 3);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clear_sum", sum, 0);
    check("clear_op_idx", op_idx, 0);
    check("clear_err", err, 0);
    check("clear_busy", busy, 0);
    tick(LAT + 2);
    check("clear_press_dropped_sum", sum, 0);
    check("clear_press_dropped_idx", op_idx, 0);
    pb = '0;
    tick(LAT + 2);
    model_acc = '0;

    // Asynchronous reset while in ADD.
    y = 4'd9; pb[0] = 1'b1;
    tick(LAT - 1);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_sum", sum, 0);
    check("async_rst_idx", op_idx, 0);
    pb = '0;
    tick(1);
    rst = 1'b0;
    tick(LAT + 2);
    check("post_rst_sum", sum, 0);

`ifdef PB_DEBOUNCE_EN
    do_clear();
    pb[0] = 1'b1; y = 4'd6;
    tick(2);
    pb = '0;
    tick(20);
    check("glitch_sum", sum, 0);
    check("glitch_idx", op_idx, 0);
    pb[0] = 1'b1;
    tick(6);
    pb = '0;
    for (int k = 0; k < 30 && op_idx != 3'd1; k++) tick(1);
    check("db_press_idx", op_idx, 1);
    check("db_press_sum", sum, 6);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
